// File: rtl/dffram_arbiter.sv
// dffram_arbiter: shares one single-port, byte-writable DFFRAM macro between
// two Wishbone-classic requesters (port 0 and port 1).
//
// Every transaction takes exactly three cycles (IDLE -> ACCESS -> ACK), so
// the RAM sees at most one access every three cycles. A strobe that is still
// held during ACK is not serviced again until the FSM is back in IDLE.
//
// Build option:
//   DFFRAM_ARB_RR_EN  defined   : round-robin between simultaneous requests
//                                 (the port that did not win last time wins).
//   DFFRAM_ARB_RR_EN  undefined : fixed priority, port 0 always wins.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no transaction; RAM pins parked at 0; arbitration on edge
// S_ACCESS | RAM pins driven from the granted port's live inputs
// S_ACK    | RAM read data returned with a one-cycle ack to the grantee

module dffram_arbiter #(
  parameter  int COLS    = 1,
  localparam int A_WIDTH = 8 + $clog2(COLS)
) (
  input  logic               CLK,
  input  logic               RESETn,

  input  logic               m0_cyc,
  input  logic               m0_stb,
  input  logic               m0_we,
  input  logic [3:0]         m0_sel,
  input  logic [A_WIDTH-1:0] m0_adr,
  input  logic [31:0]        m0_dat_i,
  output logic [31:0]        m0_dat_o,
  output logic               m0_ack,

  input  logic               m1_cyc,
  input  logic               m1_stb,
  input  logic               m1_we,
  input  logic [3:0]         m1_sel,
  input  logic [A_WIDTH-1:0] m1_adr,
  input  logic [31:0]        m1_dat_i,
  output logic [31:0]        m1_dat_o,
  output logic               m1_ack,

  output logic               ram_en,
  output logic [3:0]         ram_we,
  output logic [A_WIDTH-1:0] ram_a,
  output logic [31:0]        ram_di,
  input  logic [31:0]        ram_do
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;

  logic [1:0]         state;
  logic               grant;
  logic               last;
  logic               abort_q;

  logic               req0;
  logic               req1;
  logic               pick;

  logic               g_cyc;
  logic               g_we;
  logic [3:0]         g_sel;
  logic [A_WIDTH-1:0] g_adr;
  logic [31:0]        g_dat;

  logic               in_access;
  logic               in_ack;
  logic               ack_live;

  assign req0 = m0_cyc & m0_stb;
  assign req1 = m1_cyc & m1_stb;

`ifdef DFFRAM_ARB_RR_EN
  // With both ports asking, the one that was not served last time wins.
  assign pick = (req0 & req1) ? ~last : req1;
`else
  // Port 0 wins any contest; port 1 only gets in when port 0 is quiet.
  assign pick = ~req0;

  // last is kept up to date in both builds but fixed priority never reads it.
  logic unused_last;
  assign unused_last = last;
`endif

  // Mux of the granted port's live Wishbone inputs.
  always_comb begin
    if (grant) begin
      g_cyc = m1_cyc;
      g_we  = m1_we;
      g_sel = m1_sel;
      g_adr = m1_adr;
      g_dat = m1_dat_i;
    end else begin
      g_cyc = m0_cyc;
      g_we  = m0_we;
      g_sel = m0_sel;
      g_adr = m0_adr;
      g_dat = m0_dat_i;
    end
  end

  // Transaction sequencer: arbitrate in IDLE, one RAM cycle, one ack cycle.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state   <= S_IDLE;
      grant   <= 1'b0;
      last    <= 1'b1;
      abort_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req0 | req1) begin
            grant   <= pick;
            abort_q <= 1'b0;
            state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // The RAM commits regardless; a master that let go of cyc here
          // has abandoned the cycle and must not see an ack for it.
          abort_q <= ~g_cyc;
          state   <= S_ACK;
        end
        S_ACK: begin
          last  <= grant;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_access = (state == S_ACCESS);
  assign in_ack    = (state == S_ACK);
  assign ack_live  = in_ack & g_cyc & ~abort_q;

  // RAM pins: driven only in ACCESS, parked at zero otherwise.
  always_comb begin
    ram_en = 1'b0;
    ram_we = 4'b0000;
    ram_a  = '0;
    ram_di = 32'h0;
    if (in_access) begin
      ram_en = 1'b1;
      ram_we = g_sel & {4{g_we}};
      ram_a  = g_adr;
      ram_di = g_dat;
    end
  end

  // Per-port ack and read data; data is forced to zero whenever ack is low.
  always_comb begin
    m0_ack   = ack_live & ~grant;
    m1_ack   = ack_live &  grant;
    m0_dat_o = m0_ack ? ram_do : 32'h0;
    m1_dat_o = m1_ack ? ram_do : 32'h0;
  end

endmodule
